// File: rtl/bus_arbiter_rr.sv
// N-requester bus arbiter: round-robin or fixed priority, grant hold with
// timeout preemption. Every output is registered, so a request is granted one cycle later.
module bus_arbiter_rr #(
    parameter int unsigned  NUM_REQ  = 3,
    parameter bit           RR_MODE  = 1'b1,
    parameter int unsigned  MAX_HOLD = 16,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam int unsigned HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0]  cand_c;
    logic [ID_W-1:0]     win_id_c;
    logic                win_found_c;
    logic                owner_req_c;
    logic                others_c;
    logic                timeout_c;
    int unsigned         idx_c;

    // The current owner is never a candidate. This one mask covers the idle,
    // release and timeout cases.
    always_comb begin
        cand_c      = req & ~gnt;
        owner_req_c = |(req & gnt);
        others_c    = |cand_c;
        timeout_c   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_W'(HOLD_LIM));
    end

    // Winner search: rotate from rr_ptr+1, or lowest index in fixed mode
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = '0;
        idx_c       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (RR_MODE) begin
                idx_c = 32'(rr_ptr) + k + 32'd1;
                if (idx_c >= NUM_REQ) begin
                    idx_c = idx_c - NUM_REQ;
                end
            end else begin
                idx_c = k;
            end
            if (!win_found_c && cand_c[ID_W'(idx_c)]) begin
                win_found_c = 1'b1;
                win_id_c    = ID_W'(idx_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found_c) begin
                        state     <= OWNED;
                        gnt       <= NUM_REQ'(1) << win_id_c;
                        gnt_id    <= win_id_c;
                        gnt_valid <= 1'b1;
                        rr_ptr    <= win_id_c;
                        hold_cnt  <= '0;
                    end
                end
                OWNED: begin
                    if (owner_req_c && !(others_c && timeout_c)) begin
                        if (hold_cnt < HOLD_W'(MAX_HOLD)) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else if (win_found_c) begin
                        // Owner still requesting here means a timeout handover
                        gnt       <= NUM_REQ'(1) << win_id_c;
                        gnt_id    <= win_id_c;
                        gnt_valid <= 1'b1;
                        rr_ptr    <= win_id_c;
                        hold_cnt  <= '0;
                        preempt   <= owner_req_c;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench: one round-robin instance and one fixed-priority instance, both with MAX_HOLD=4.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [2:0] req_a;
    logic [2:0] req_b;
    logic [2:0] gnt_a;
    logic [2:0] gnt_b;
    logic [1:0] id_a;
    logic [1:0] id_b;
    logic       valid_a;
    logic       valid_b;
    logic       pre_a;
    logic       pre_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.NUM_REQ(3), .RR_MODE(1'b1), .MAX_HOLD(4)) dut_rr (
        .clk       (clk),
        .rst       (rst_a),
        .req       (req_a),
        .gnt       (gnt_a),
        .gnt_id    (id_a),
        .gnt_valid (valid_a),
        .preempt   (pre_a)
    );

    bus_arbiter_rr #(.NUM_REQ(3), .RR_MODE(1'b0), .MAX_HOLD(4)) dut_fp (
        .clk       (clk),
        .rst       (rst_b),
        .req       (req_b),
        .gnt       (gnt_b),
        .gnt_id    (id_b),
        .gnt_valid (valid_b),
        .preempt   (pre_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {gnt, gnt_id, gnt_valid, preempt}. gnt_id is compared only while a grant is valid.
    task automatic chk_a(input string tag, input logic [2:0] g, input logic [1:0] id,
                         input logic v, input logic p);
        chk(tag, 32'({gnt_a, (valid_a ? id_a : 2'd0), valid_a, pre_a}),
                 32'({g, (v ? id : 2'd0), v, p}));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] g, input logic [1:0] id,
                         input logic v, input logic p);
        chk(tag, 32'({gnt_b, (valid_b ? id_b : 2'd0), valid_b, pre_b}),
                 32'({g, (v ? id : 2'd0), v, p}));
    endtask

    initial begin
        int owner;
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = 3'b111;
        req_b = 3'b000;

        // Reset held for three cycles while everyone requests
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a($sformatf("reset_c%0d", i), 3'b000, 2'd0, 1'b0, 1'b0);
        end

        // A lone requester is granted after one cycle and keeps the grant past MAX_HOLD
        rst_a = 1'b0;
        req_a = 3'b010;
        tick();
        chk_a("single_grant", 3'b010, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_a($sformatf("single_hold%0d", i), 3'b010, 2'd1, 1'b1, 1'b0);
        end
        req_a = 3'b000;
        tick();
        chk_a("single_release", 3'b000, 2'd0, 1'b0, 1'b0);

        // Round robin with steady contention: 4 cycles per owner, pulse at each handover
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        req_a = 3'b111;
        for (int t = 1; t <= 16; t++) begin
            tick();
            owner = ((t - 1) / 4) % 3;
            chk_a($sformatf("rr_t%0d", t), 3'b001 << owner, 2'(owner), 1'b1,
                  (t > 1) && ((t - 1) % 4 == 0));
        end

        // Release handover: the bus passes straight to requester 2 with no idle cycle
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        req_a = 3'b101;
        tick();
        chk_a("rel_grant0", 3'b001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_a("rel_hold0", 3'b001, 2'd0, 1'b1, 1'b0);
        req_a = 3'b100;
        tick();
        chk_a("rel_handover", 3'b100, 2'd2, 1'b1, 1'b0);

        // Reset during ownership, then the search restarts at requester 0
        rst_a = 1'b1;
        tick();
        chk_a("midrst_drop", 3'b000, 2'd0, 1'b0, 1'b0);
        rst_a = 1'b0;
        req_a = 3'b111;
        tick();
        chk_a("midrst_regrant", 3'b001, 2'd0, 1'b1, 1'b0);
        rst_a = 1'b1;

        // Fixed priority: requester 1 keeps the bus until timeout, then 0 takes it
        rst_b = 1'b0;
        req_b = 3'b110;
        tick();
        chk_b("fp_grant1", 3'b010, 2'd1, 1'b1, 1'b0);
        req_b = 3'b111;
        for (int t = 2; t <= 4; t++) begin
            tick();
            chk_b($sformatf("fp_hold1_t%0d", t), 3'b010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        chk_b("fp_preempt_to0", 3'b001, 2'd0, 1'b1, 1'b1);
        for (int t = 6; t <= 8; t++) begin
            tick();
            chk_b($sformatf("fp_hold0_t%0d", t), 3'b001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        chk_b("fp_preempt_to1", 3'b010, 2'd1, 1'b1, 1'b1);
        req_b = 3'b100;
        tick();
        chk_b("fp_release_to2", 3'b100, 2'd2, 1'b1, 1'b0);
        req_b = 3'b000;
        tick();
        chk_b("fp_idle", 3'b000, 2'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
